// File: rtl/uart_arb_pkg.sv
// Shared types and sizes for the UART transmit arbiter.
package uart_arb_pkg;

  localparam int unsigned NREQ_DEFAULT = 3;
  localparam int unsigned BYTE_W       = 8;
  localparam int unsigned COUNT_W      = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set bit of mask searching upward from last+1, wrapping.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int unsigned N  = NREQ_DEFAULT,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  // Walk offsets 1..N from last; constant bit indices keep the select width-clean.
  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    for (int unsigned off = 0; off < N; off++) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && mask[i] && (((32'(last) + 32'd1 + off) % N) == i)) begin
          found     = 1'b1;
          idx       = IW'(i);
          onehot[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NREQ byte producers with round-robin
// arbitration and an optional per-requester lock for multi-byte words.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int unsigned NREQ = NREQ_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [BYTE_W*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]          req_lock,
  output logic [NREQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]        tx_data,
  output logic                     tx_start,
  input  logic                     tx_busy,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic [COUNT_W-1:0]       byte_count
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state;
  logic [IW-1:0]     last;
  logic [IW-1:0]     owner;
  logic              locked;

  logic [NREQ-1:0]   owner_oh;
  logic [NREQ-1:0]   elig;
  logic [NREQ-1:0]   pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_found;
  logic [BYTE_W-1:0] pick_byte;
  logic              pick_lock;
  logic              owner_lock;
  logic              owner_valid;
  logic              accept;
  logic              abandon;

  // Decode the lock owner index to a one-hot mask.
  always_comb begin
    owner_oh = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      owner_oh[i] = (owner == IW'(i));
    end
  end

  // While locked only the owner may be picked.
  assign elig = locked ? (req_valid & owner_oh) : req_valid;

  rr_pick #(
    .N  (NREQ),
    .IW (IW)
  ) u_pick (
    .mask   (elig),
    .last   (last),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  // Mux out the chosen requester's byte.
  always_comb begin
    pick_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_oh[i]) pick_byte = req_data[i*BYTE_W +: BYTE_W];
    end
  end

  assign pick_lock   = |(req_lock & pick_oh);
  assign owner_lock  = |(req_lock & owner_oh);
  assign owner_valid = |(req_valid & owner_oh);

  // Accept only in IDLE with the transmitter quiet; owner giving up the lock frees the bus.
  assign accept    = (state == ST_IDLE) && !tx_busy && pick_found;
  assign abandon   = (state == ST_IDLE) && locked && !owner_lock && !owner_valid;
  assign req_ready = accept ? pick_oh : '0;
  assign busy      = (state != ST_IDLE) || tx_busy;

  // Arbitration FSM: IDLE accepts a byte, ARM pulses start, WAIT rides out tx_busy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      last       <= IW'(NREQ - 1);
      owner      <= '0;
      locked     <= 1'b0;
      tx_data    <= '0;
      tx_start   <= 1'b0;
      grant      <= '0;
      byte_count <= '0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_ARM;
            tx_data  <= pick_byte;
            tx_start <= 1'b1;
            last     <= pick_idx;
            owner    <= pick_idx;
            locked   <= pick_lock;
            grant    <= pick_oh;
          end else if (abandon) begin
            locked <= 1'b0;
            grant  <= '0;
          end
        end
        ST_ARM: begin
          byte_count <= byte_count + 32'd1;
          state      <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!tx_busy) begin
            state <= ST_IDLE;
            if (!locked) grant <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
